fwd_hazard_unit: RTL

Pipelined forwarding and load-use hazard unit for the 5-stage MIPS datapath. It tracks destination-register ownership for the instructions in EX, MEM and WB, and produces the 2-bit operand selects that drive the ALU-input 3-to-1 muxes. It also raises a one-cycle stall for load-use hazards and counts stalls for performance reporting. It sits beside the ID/EX pipeline register and is the producer of the mux select encoding.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_match.sv | 17 +
 rtl/fwd_hazard_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and select encodings for the forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_entry_t;

    // Newest producer wins; a load in EX cannot forward (it stalls instead).
    function automatic logic [1:0] fwd_select(input logic bubble, input logic ex_hit,
                                              input logic ex_load, input logic mem_hit);
        if (bubble)                return FWD_RF;
        else if (ex_hit && !ex_load) return FWD_MEM;
        else if (mem_hit)          return FWD_WB;
        else                       return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational producer match: does this pipeline entry write the register being read?
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    input  stage_entry_t     entry_i,
    output logic             hit_o
);

    logic unused_memread;
    assign unused_memread = entry_i.memread;

    assign hit_o = use_i && entry_i.valid && entry_i.regwrite &&
                   (entry_i.rd != '0) && (entry_i.rd == src_i);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM/WB destination ownership, registers ALU operand selects,
// raises the load-use stall and keeps a saturating stall counter.
module fwd_hazard_unit #(
    parameter int REG_W = fwd_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    import fwd_pkg::*;

    stage_entry_t     ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, lu_hit_a, lu_hit_b;
    logic             stall, bubble;

    fwd_match u_ex_a  (.src_i(id_rs_i), .use_i(id_use_rs_i), .entry_i(ex_q),  .hit_o(ex_hit_a));
    fwd_match u_ex_b  (.src_i(id_rt_i), .use_i(id_use_rt_i), .entry_i(ex_q),  .hit_o(ex_hit_b));
    fwd_match u_mem_a (.src_i(id_rs_i), .use_i(id_use_rs_i), .entry_i(mem_q), .hit_o(mem_hit_a));
    fwd_match u_mem_b (.src_i(id_rt_i), .use_i(id_use_rt_i), .entry_i(mem_q), .hit_o(mem_hit_b));
    fwd_match u_lu_a  (.src_i(id_rs_i), .use_i(id_use_rs_i), .entry_i(ex_q),  .hit_o(lu_hit_a));
    fwd_match u_lu_b  (.src_i(id_rt_i), .use_i(id_use_rt_i), .entry_i(ex_q),  .hit_o(lu_hit_b));

    assign stall  = id_valid_i && !flush_i && ex_q.memread && (lu_hit_a || lu_hit_b);
    assign bubble = stall || flush_i || !id_valid_i;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    assign fwd_a_d     = fwd_select(bubble, ex_hit_a, ex_q.memread, mem_hit_a);
    assign fwd_b_d     = fwd_select(bubble, ex_hit_b, ex_q.memread, mem_hit_b);
    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // WB ownership is tracked but never consumed: the register file is write-first.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_o     = stall;
    assign stall_cnt_o = stall_cnt_q;

endmodule
